// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The buffer keeps its per-entry tag (live bit, rd) apart from the XLEN-wide data.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Per-entry tag; the data word is held in a parallel array sized by XLEN
    typedef struct packed {
        logic      live;
        reg_addr_t rd;
    } buf_tag_t;

    // True when a source query names a real register written by rd
    function automatic logic rd_hit(input reg_addr_t q, input reg_addr_t rd);
        return (q != '0) && (q == rd);
    endfunction

endpackage

// File: rtl/regfile_wr_buffer.sv
// Circular holding buffer for long-latency results awaiting the write port.
// Entries carry a live bit that a younger writeback write can clear.
module regfile_wr_buffer
    import regfile_write_arbiter_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enq,
    input  logic [4:0]      enq_rd,
    input  logic [XLEN-1:0] enq_data,
    input  logic            deq,
    input  logic            kill_en,
    input  logic [4:0]      kill_rd,
    input  logic [4:0]      q_rd1,
    input  logic [4:0]      q_rd2,
    output logic [CW-1:0]   count,
    output logic            head_live,
    output logic [4:0]      head_rd,
    output logic [XLEN-1:0] head_data,
    output logic            match1,
    output logic            match2
);

    buf_tag_t          tag_q  [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Entry state: kill first, then dequeue, then enqueue so a new entry stays live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && tag_q[i].live && tag_q[i].rd == kill_rd) begin
                    tag_q[i].live <= 1'b0;
                end
            end
            if (deq) begin
                tag_q[rd_ptr_q].live <= 1'b0;
                rd_ptr_q             <= ptr_inc(rd_ptr_q);
            end
            if (enq) begin
                tag_q[wr_ptr_q]  <= '{live: 1'b1, rd: enq_rd};
                data_q[wr_ptr_q] <= enq_data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
        end
    end

    // Occupancy: +1, -1, or unchanged when enqueue and dequeue coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Pending-destination match against live entries only
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_q[i].live && rd_hit(q_rd1, tag_q[i].rd)) begin
                match1 = 1'b1;
            end
            if (tag_q[i].live && rd_hit(q_rd2, tag_q[i].rd)) begin
                match2 = 1'b1;
            end
        end
    end

    assign count     = count_q;
    assign head_live = tag_q[rd_ptr_q].live;
    assign head_rd   = tag_q[rd_ptr_q].rd;
    assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a long-latency unit.
// Writeback wins; deferred LL results drain from a small buffer when the port is free.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            LLValid,
    input  logic [4:0]      LLRd,
    input  logic [XLEN-1:0] LLResult,
    output logic            LLReady,
    input  logic [4:0]      QueryRs1,
    input  logic [4:0]      QueryRs2,
    output logic            Rs1Pending,
    output logic            Rs2Pending,
    output logic            RegWriteOut,
    output logic [4:0]      RdOut,
    output logic [XLEN-1:0] WriteDataOut,
    output logic            StallReq,
    output logic [CW-1:0]   BufCount
);

    logic            wb_wr;
    logic            ll_xfer;
    logic            ll_real;
    logic            buf_ne;
    logic            head_gnt;
    logic            bypass;
    logic            enq;
    logic [CW-1:0]   buf_count;
    logic            head_live;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            hit1;
    logic            hit2;
    logic [SW-1:0]   starve_q;

    assign wb_wr    = RegWriteW && (RdW != '0);
    assign LLReady  = rst_n && (buf_count < CW'(DEPTH));
    assign ll_xfer  = LLValid && LLReady;
    assign ll_real  = ll_xfer && (LLRd != '0);
    assign buf_ne   = (buf_count != '0);
    assign head_gnt = !wb_wr && buf_ne;
    assign bypass   = !wb_wr && !buf_ne && ll_real;
    assign enq      = ll_real && !bypass;

    regfile_wr_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (enq),
        .enq_rd    (LLRd),
        .enq_data  (LLResult),
        .deq       (head_gnt),
        .kill_en   (wb_wr),
        .kill_rd   (RdW),
        .q_rd1     (QueryRs1),
        .q_rd2     (QueryRs2),
        .count     (buf_count),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .match1    (hit1),
        .match2    (hit2)
    );

    // Write-port grant: writeback, then buffer head, then LL bypass
    always_comb begin
        RegWriteOut  = 1'b0;
        RdOut        = '0;
        WriteDataOut = '0;
        if (rst_n) begin
            unique case (1'b1)
                wb_wr: begin
                    RegWriteOut  = 1'b1;
                    RdOut        = RdW;
                    WriteDataOut = ResultW;
                end
                head_gnt: begin
                    RegWriteOut  = head_live;
                    RdOut        = head_rd;
                    WriteDataOut = head_data;
                end
                bypass: begin
                    RegWriteOut  = 1'b1;
                    RdOut        = LLRd;
                    WriteDataOut = LLResult;
                end
                default: begin
                    RegWriteOut  = 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles the non-empty buffer is denied the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!buf_ne || head_gnt) begin
            starve_q <= '0;
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign StallReq   = rst_n && (starve_q >= SW'(STARVE_LIMIT));
    assign Rs1Pending = rst_n && (hit1 || (bypass && LLRd == QueryRs1));
    assign Rs2Pending = rst_n && (hit2 || (bypass && LLRd == QueryRs2));
    assign BufCount   = buf_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        LLValid;
    logic [4:0]  LLRd;
    logic [31:0] LLResult;
    logic        LLReady;
    logic [4:0]  QueryRs1;
    logic [4:0]  QueryRs2;
    logic        Rs1Pending;
    logic        Rs2Pending;
    logic        RegWriteOut;
    logic [4:0]  RdOut;
    logic [31:0] WriteDataOut;
    logic        StallReq;
    logic [1:0]  BufCount;

    logic [31:0] rf [32];
    int errors;
    int checks;

    regfile_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .LLValid      (LLValid),
        .LLRd         (LLRd),
        .LLResult     (LLResult),
        .LLReady      (LLReady),
        .QueryRs1     (QueryRs1),
        .QueryRs2     (QueryRs2),
        .Rs1Pending   (Rs1Pending),
        .Rs2Pending   (Rs2Pending),
        .RegWriteOut  (RegWriteOut),
        .RdOut        (RdOut),
        .WriteDataOut (WriteDataOut),
        .StallReq     (StallReq),
        .BufCount     (BufCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWriteOut) rf[RdOut] <= WriteDataOut;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic wbw, input logic [4:0] rdw,
                       input logic [31:0] resw, input logic llv,
                       input logic [4:0] llrd, input logic [31:0] llres);
        @(negedge clk);
        RegWriteW = wbw;
        RdW       = rdw;
        ResultW   = resw;
        LLValid   = llv;
        LLRd      = llrd;
        LLResult  = llres;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0;
        RegWriteW = 0; RdW = 0; ResultW = 0;
        LLValid = 0; LLRd = 0; LLResult = 0;
        QueryRs1 = 0; QueryRs2 = 0;
        #2;
        chk("rst_count", 32'(BufCount), 0);
        chk("rst_we", 32'(RegWriteOut), 0);
        chk("rst_ready", 32'(LLReady), 0);
        chk("rst_stall", 32'(StallReq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(LLReady), 1);

        // Bypass
        QueryRs1 = 5;
        drv(0, 0, 0, 1, 5, 32'hDEADBEEF);
        chk("byp_we", 32'(RegWriteOut), 1);
        chk("byp_rd", 32'(RdOut), 5);
        chk("byp_data", WriteDataOut, 32'hDEADBEEF);
        chk("byp_pend", 32'(Rs1Pending), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("byp_count", 32'(BufCount), 0);
        chk("byp_rf", rf[5], 32'hDEADBEEF);
        chk("byp_idle_we", 32'(RegWriteOut), 0);

        // Conflict with writeback
        QueryRs2 = 7;
        drv(1, 3, 32'h11, 1, 7, 32'h22);
        chk("cf_rd0", 32'(RdOut), 3);
        chk("cf_data0", WriteDataOut, 32'h11);
        drv(0, 0, 0, 0, 0, 0);
        chk("cf_count1", 32'(BufCount), 1);
        chk("cf_we1", 32'(RegWriteOut), 1);
        chk("cf_rd1", 32'(RdOut), 7);
        chk("cf_data1", WriteDataOut, 32'h22);
        chk("cf_pend2", 32'(Rs2Pending), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("cf_count0", 32'(BufCount), 0);
        chk("cf_rf7", rf[7], 32'h22);
        chk("cf_rf3", rf[3], 32'h11);

        // Full buffer and starvation
        drv(1, 10, 1, 1, 12, 32'h120);
        chk("full_a_ready", 32'(LLReady), 1);
        drv(1, 10, 2, 1, 13, 32'h130);
        chk("full_b_count", 32'(BufCount), 1);
        chk("full_b_stall", 32'(StallReq), 0);
        drv(1, 10, 3, 1, 14, 32'h140);
        chk("full_c_ready", 32'(LLReady), 0);
        chk("full_c_count", 32'(BufCount), 2);
        drv(1, 10, 3, 1, 14, 32'h140);
        chk("full_d_count", 32'(BufCount), 2);
        drv(1, 10, 3, 1, 14, 32'h140);
        chk("st_e_stall", 32'(StallReq), 0);
        drv(1, 10, 3, 1, 14, 32'h140);
        chk("st_f_stall", 32'(StallReq), 1);
        chk("st_f_count", 32'(BufCount), 2);
        drv(0, 0, 0, 1, 14, 32'h140);
        chk("st_g_we", 32'(RegWriteOut), 1);
        chk("st_g_rd", 32'(RdOut), 12);
        chk("st_g_data", WriteDataOut, 32'h120);
        chk("st_g_ready", 32'(LLReady), 0);
        drv(0, 0, 0, 1, 14, 32'h140);
        chk("st_h_stall", 32'(StallReq), 0);
        chk("st_h_ready", 32'(LLReady), 1);
        chk("st_h_rd", 32'(RdOut), 13);
        chk("st_h_data", WriteDataOut, 32'h130);
        drv(0, 0, 0, 0, 0, 0);
        chk("st_i_count", 32'(BufCount), 1);
        chk("st_i_rd", 32'(RdOut), 14);
        chk("st_i_data", WriteDataOut, 32'h140);
        drv(0, 0, 0, 0, 0, 0);
        chk("st_j_count", 32'(BufCount), 0);
        chk("st_rf12", rf[12], 32'h120);
        chk("st_rf13", rf[13], 32'h130);
        chk("st_rf14", rf[14], 32'h140);

        // Kill by younger writeback
        drv(1, 1, 1, 1, 9, 32'hAA);
        QueryRs1 = 9;
        drv(1, 9, 32'hBB, 0, 0, 0);
        chk("kill_pend_pre", 32'(Rs1Pending), 1);
        chk("kill_wb_rd", 32'(RdOut), 9);
        drv(0, 0, 0, 0, 0, 0);
        chk("kill_head_we", 32'(RegWriteOut), 0);
        chk("kill_pend_post", 32'(Rs1Pending), 0);
        chk("kill_count", 32'(BufCount), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("kill_count0", 32'(BufCount), 0);
        chk("kill_rf9", rf[9], 32'hBB);

        // Kill and enqueue to the same rd in one cycle
        QueryRs1 = 20;
        drv(1, 1, 1, 1, 20, 32'h1);
        drv(1, 20, 32'h5, 1, 20, 32'h77);
        chk("ke_pend_p", 32'(Rs1Pending), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("ke_head_we", 32'(RegWriteOut), 0);
        chk("ke_pend_q", 32'(Rs1Pending), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("ke_we", 32'(RegWriteOut), 1);
        chk("ke_rd", 32'(RdOut), 20);
        chk("ke_data", WriteDataOut, 32'h77);
        drv(0, 0, 0, 0, 0, 0);
        chk("ke_count", 32'(BufCount), 0);
        chk("ke_rf20", rf[20], 32'h77);

        // LL to x0 is discarded; WB to x0 leaves the port to a bypass
        drv(0, 0, 0, 1, 0, 32'h99);
        chk("x0_ll_we", 32'(RegWriteOut), 0);
        drv(1, 0, 32'h55, 1, 6, 32'h66);
        chk("x0_ll_count", 32'(BufCount), 0);
        chk("x0_wb_we", 32'(RegWriteOut), 1);
        chk("x0_wb_rd", 32'(RdOut), 6);
        chk("x0_wb_data", WriteDataOut, 32'h66);

        // Asynchronous reset with a full, starving buffer
        QueryRs1 = 21;
        QueryRs2 = 22;
        drv(1, 10, 0, 1, 21, 32'h21);
        drv(1, 10, 0, 1, 22, 32'h22);
        for (int i = 0; i < 4; i++) drv(1, 10, 0, 0, 0, 0);
        chk("rs_pre_stall", 32'(StallReq), 1);
        chk("rs_pre_count", 32'(BufCount), 2);
        chk("rs_pre_pend", 32'(Rs1Pending), 1);
        rst_n = 1'b0;
        #1;
        chk("rs_count", 32'(BufCount), 0);
        chk("rs_stall", 32'(StallReq), 0);
        chk("rs_we", 32'(RegWriteOut), 0);
        chk("rs_rd", 32'(RdOut), 0);
        chk("rs_pend1", 32'(Rs1Pending), 0);
        chk("rs_pend2", 32'(Rs2Pending), 0);
        chk("rs_ready", 32'(LLReady), 0);
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        chk("rs_rel_ready", 32'(LLReady), 1);
        chk("rs_rel_we", 32'(RegWriteOut), 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("rs_rel_we2", 32'(RegWriteOut), 0);
        chk("rs_rel_count", 32'(BufCount), 0);
        chk("rs_rf21", rf[21], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
